// File: rtl/tftp_hdr_encode.sv
// TFTP header byte-stream encoder for DATA, ACK and ERROR packets.
// Emits opcode and block/error fields over a valid/ready byte stream.
module tftp_hdr_encode #(
  parameter bit ERR_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pkt_type,
  input  logic [15:0] block_no,
  input  logic [7:0]  err_code,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        bad_type
);

  localparam logic [1:0] T_ERR = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  typ_q;
  logic [15:0] blk_q;
  logic [7:0]  ec_q;
  logic        done_q, bad_q;
  logic        accept, xfer;
  logic [2:0]  last_idx;

  assign accept   = (state_q == IDLE) & start
                  & (pkt_type != T_BAD);
  assign last_idx = ((typ_q == T_ERR) && ERR_TERM)
                  ? 3'd4 : 3'd3;
  assign tx_valid = (state_q == SEND);
  assign tx_last  = tx_valid & (idx_q == last_idx);
  assign xfer     = tx_valid & tx_ready;
  assign busy     = (state_q == SEND);
  assign done     = done_q;
  assign bad_type = bad_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (tx_last) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  // Opcode is 3/4/5 for DATA/ACK/ERROR, i.e. 3 + type
  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0: tx_data = 8'h00;
        3'd1: tx_data = 8'h03 + {6'd0, typ_q};
        3'd2: tx_data = (typ_q == T_ERR)
                      ? 8'h00 : blk_q[15:8];
        3'd3: tx_data = (typ_q == T_ERR)
                      ? ec_q : blk_q[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      typ_q   <= 2'b00;
      blk_q   <= 16'h0000;
      ec_q    <= 8'h00;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        typ_q <= pkt_type;
        blk_q <= block_no;
        ec_q  <= err_code;
      end
      done_q <= xfer & tx_last;
      bad_q  <= (state_q == IDLE) & start
              & (pkt_type == T_BAD);
    end
  end

endmodule

// File: tb/tb_tftp_hdr_encode.sv
// Bench for tftp_hdr_encode: one DUT per ERR_TERM setting,
// shared stimulus, per-DUT expected-byte scoreboards.
module tb_tftp_hdr_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pkt_type = 2'b00;
  logic [15:0] block_no = 16'h0000;
  logic [7:0]  err_code = 8'h00;
  logic        tx_ready = 1'b0;

  logic [7:0] tx_data_s [2];
  logic       tx_valid_s [2];
  logic       tx_last_s [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic       bad_s [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tftp_hdr_encode #(.ERR_TERM(1'b1)) dut_t1 (
    .clk(clk), .reset(reset), .start(start),
    .pkt_type(pkt_type), .block_no(block_no),
    .err_code(err_code), .tx_ready(tx_ready),
    .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
    .tx_last(tx_last_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .bad_type(bad_s[0])
  );

  tftp_hdr_encode #(.ERR_TERM(1'b0)) dut_t0 (
    .clk(clk), .reset(reset), .start(start),
    .pkt_type(pkt_type), .block_no(block_no),
    .err_code(err_code), .tx_ready(tx_ready),
    .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
    .tx_last(tx_last_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .bad_type(bad_s[1])
  );

  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_t;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] blk;
    logic [7:0]  ec;
    logic [39:0] bytes;
    int          n1;
    int          n0;
  } vec_t;

  exp_t sbq [2][$];
  vec_t tbl [7];

  task automatic chk(string nm, int k,
                     logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t",
               nm, k, got, want, $time);
    end
  endtask

  logic       exp_done [2] = '{1'b0, 1'b0};
  logic       exp_bad [2] = '{1'b0, 1'b0};
  logic       hold [2] = '{1'b0, 1'b0};
  logic [7:0] hold_d [2];
  logic       hold_l [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      chk("done", k, {15'd0, done_s[k]}, {15'd0, exp_done[k]});
      chk("bad_type", k, {15'd0, bad_s[k]}, {15'd0, exp_bad[k]});
      if (hold[k]) begin
        chk("hold_valid", k, {15'd0, tx_valid_s[k]}, 16'd1);
        chk("hold_data", k, {8'd0, tx_data_s[k]}, {8'd0, hold_d[k]});
        chk("hold_last", k, {15'd0, tx_last_s[k]}, {15'd0, hold_l[k]});
      end
      exp_done[k] <= 1'b0;
      exp_bad[k]  <= !busy_s[k] && start && pkt_type == 2'b11 && !reset;
      hold[k]     <= tx_valid_s[k] && !tx_ready && !reset;
      hold_d[k]   <= tx_data_s[k];
      hold_l[k]   <= tx_last_s[k];
      if (!reset && tx_valid_s[k] && tx_ready) begin
        if (sbq[k].size() == 0) begin
          chk("unexpected_byte", k, {8'd0, tx_data_s[k]}, 16'hFFFF);
        end else begin
          e = sbq[k].pop_front();
          chk("data", k, {8'd0, tx_data_s[k]}, {8'd0, e.b});
          chk("last", k, {15'd0, tx_last_s[k]}, {15'd0, e.l});
          exp_done[k] <= e.l;
        end
      end
    end
  end

  task automatic push_frame(int i);
    for (int j = 0; j < tbl[i].n1; j++)
      sbq[0].push_back('{tbl[i].bytes[39-8*j -: 8], j == tbl[i].n1 - 1});
    for (int j = 0; j < tbl[i].n0; j++)
      sbq[1].push_back('{tbl[i].bytes[39-8*j -: 8], j == tbl[i].n0 - 1});
  endtask

  task automatic run_frame(int i, bit bp, bit disturb, bit nowait);
    int cyc = 0;
    int lat0 = -1;
    int lat1 = -1;
    if (!nowait) begin
      @(posedge clk); #1;
    end
    start    = 1'b1;
    pkt_type = tbl[i].t;
    block_no = tbl[i].blk;
    err_code = tbl[i].ec;
    tx_ready = 1'b1;
    push_frame(i);
    do begin
      @(posedge clk); #1;
      cyc++;
      start = disturb && cyc == 2;
      if (disturb) begin
        pkt_type = (tbl[i].t == 2'b00) ? 2'b01 : 2'b00;
        block_no = 16'($urandom);
        err_code = 8'($urandom);
      end
      tx_ready = bp ? ((cyc - 1) % 3 == 0) : 1'b1;
      if (done_s[0] && lat0 < 0) lat0 = cyc;
      if (done_s[1] && lat1 < 0) lat1 = cyc;
    end while (cyc < 80 &&
               (lat0 < 0 || lat1 < 0 || busy_s[0] || busy_s[1]));
    if (lat0 < 0) chk("timeout", 0, 16'd0, 16'd1);
    if (lat1 < 0) chk("timeout", 1, 16'd0, 16'd1);
    if (!bp) begin
      chk("latency", 0, 16'(lat0), 16'(tbl[i].n1 + 1));
      chk("latency", 1, 16'(lat1), 16'(tbl[i].n0 + 1));
    end
    chk("sb_empty", 0, 16'(sbq[0].size()), 16'd0);
    chk("sb_empty", 1, 16'(sbq[1].size()), 16'd0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 16'h1234, 8'h00, 40'h0004123400, 4, 4};
    tbl[1] = '{2'b10, 16'h0000, 8'h02, 40'h0005000200, 5, 4};
    tbl[2] = '{2'b00, 16'hFFFF, 8'h00, 40'h0003FFFF00, 4, 4};
    tbl[3] = '{2'b00, 16'h0001, 8'h77, 40'h0003000100, 4, 4};
    tbl[4] = '{2'b10, 16'hABCD, 8'hFF, 40'h000500FF00, 5, 4};
    tbl[5] = '{2'b01, 16'h0000, 8'h55, 40'h0004000000, 4, 4};
    tbl[6] = '{2'b00, 16'h8000, 8'h00, 40'h0003800000, 4, 4};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, {15'd0, tx_valid_s[k]}, 16'd0);
      chk("rst_last", k, {15'd0, tx_last_s[k]}, 16'd0);
      chk("rst_data", k, {8'd0, tx_data_s[k]}, 16'd0);
      chk("rst_busy", k, {15'd0, busy_s[k]}, 16'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame(i, i == 2, i == 3, 1'b0);

    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0, 1'b1);
    run_frame(6, 1'b0, 1'b0, 1'b1);

    @(posedge clk); #1;
    start = 1'b1;
    pkt_type = 2'b11;
    block_no = 16'h4242;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("bt_pulse", k, {15'd0, bad_s[k]}, 16'd1);
      chk("bt_valid", k, {15'd0, tx_valid_s[k]}, 16'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("bt_clear", k, {15'd0, bad_s[k]}, 16'd0);
      chk("bt_valid2", k, {15'd0, tx_valid_s[k]}, 16'd0);
    end

    @(posedge clk); #1;
    start = 1'b1;
    pkt_type = 2'b01;
    block_no = 16'h5678;
    tx_ready = 1'b1;
    sbq[0].push_back('{8'h00, 1'b0});
    sbq[0].push_back('{8'h04, 1'b0});
    sbq[0].push_back('{8'h56, 1'b0});
    sbq[0].push_back('{8'h78, 1'b1});
    sbq[1] = sbq[0];
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mid_left", k, 16'(sbq[k].size()), 16'd2);
      chk("rst_mid_valid", k, {15'd0, tx_valid_s[k]}, 16'd0);
      chk("rst_mid_busy", k, {15'd0, busy_s[k]}, 16'd0);
      sbq[k].delete();
    end
    repeat (3) @(posedge clk);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tftp_hdr_encode.md
TFTP_HDR_ENCODE -- requirements
Module: tftp_hdr_encode

Interface
REQ-001 Parameter: ERR_TERM, default 1, meaning 1 = ERROR packet ends with a 0x00 message terminator byte, 0 = terminator omitted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to emit one header.
REQ-005 pkt_type  input  2  header type: 00 DATA, 01 ACK, 10 ERROR, 11 reserved.
REQ-006 block_no  input  16  block number for DATA/ACK, big-endian on the wire.
REQ-007 err_code  input  8  low byte of the ERROR code (high byte is always 0x00).
REQ-008 tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-009 tx_data  output  8  current header byte.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_last  output  1  tx_data is the final header byte.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 done  output  1  one-cycle pulse after the final byte is accepted.
REQ-014 bad_type  output  1  one-cycle pulse when start arrives with pkt_type 11.

Function
REQ-015 FSM states SHALL be IDLE and SEND, with a byte index counter of 3 bits.
REQ-016 In IDLE, start with a valid pkt_type SHALL latch pkt_type, block_no and err_code, clear the index to 0 and enter SEND on the next edge.
REQ-017 Byte sequences SHALL be as follows: DATA 00 03 BH BL; ACK 00 04 BH BL; ERROR 00 05 00 EC, followed by 00 when ERR_TERM=1. BH/BL are the latched block_no[15:8]/[7:0] and EC is the latched err_code.
REQ-018 Frame length SHALL be 4 bytes for DATA/ACK, and 5 (ERR_TERM=1) or 4 (ERR_TERM=0) for ERROR.
REQ-019 tx_valid SHALL be 1 throughout SEND and 0 in IDLE; the first byte is valid the cycle after start.
REQ-020 A byte is transferred when tx_valid & tx_ready; the index SHALL advance only on transfer.
REQ-021 While tx_valid & ~tx_ready, tx_data and tx_last SHALL hold stable.
REQ-022 tx_last SHALL be 1 exactly while the final byte of the frame is presented.
REQ-023 On transfer of the final byte, the FSM SHALL return to IDLE, and done SHALL pulse high for the following cycle.
REQ-024 busy SHALL equal (state == SEND).
REQ-025 start while busy SHALL be ignored, and input changes while busy SHALL NOT affect the current frame.
REQ-026 start in the cycle done is high (FSM in IDLE) SHALL be accepted normally.
REQ-027 start with pkt_type 11 in IDLE SHALL emit no bytes, keep the FSM in IDLE and pulse bad_type high for the following cycle.
REQ-028 Throughput with tx_ready held high SHALL be one byte per cycle: start at cycle N gives bytes at N+1..N+4 and done at N+5 for a 4-byte frame.

Reset
REQ-029 Reset SHALL force IDLE, index=0, tx_valid=0, tx_last=0, tx_data=0x00, busy=0, done=0, bad_type=0, and latched fields to 0.
REQ-030 Reset mid-frame SHALL abandon the frame; tx_valid SHALL be 0 the cycle after reset, and no done pulse SHALL be produced.
REQ-031 Reset SHALL take priority over start and tx_ready in the same cycle.

Verification
REQ-032 ACK with tx_ready=1: start, type 01, block_no 0x1234 -> bytes 00,04,12,34 on 4 consecutive cycles, tx_last on 0x34, done one cycle later.
REQ-033 ERROR with ERR_TERM=1: type 10, err_code 0x02 -> bytes 00,05,00,02,00, tx_last on the fifth byte; with ERR_TERM=0 -> 4 bytes, tx_last on 0x02.
REQ-034 Backpressure: DATA, block_no 0xFFFF, tx_ready toggling 1,0,0,1,... -> tx_data held stable during stalls, the sequence 00,03,FF,FF is intact, and done follows the last transfer.
REQ-035 Start while busy with different type and block_no -> ignored and the current frame is unchanged; start in the done cycle -> a new frame begins the next cycle.
REQ-036 Type 11 -> bad_type pulse, tx_valid stays 0; reset asserted after the second byte -> tx_valid 0 next cycle, no done pulse, and a following ACK frame is correct.
